// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg: shared constants, FSM states and result record for the error monitor
package approx_adder_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 32;
    localparam int ACC_W_DEF = 48;
    localparam int SUM_W_DEF = WIDTH_DEF + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    typedef struct packed {
        logic [ACC_W_DEF-1:0] sum_abs_err;
        logic [SUM_W_DEF-1:0] max_err;
        logic [CNT_W_DEF-1:0] err_count;
        logic [CNT_W_DEF-1:0] samples;
    } result_t;
endpackage

// File: rtl/approx_adder_error_monitor_err_stage.sv
// approx_err_stage: absolute error register plus saturating sum, max and count accumulators
module approx_err_stage
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             v_i,
    input  logic [WIDTH:0]   exact_i,
    input  logic [WIDTH:0]   approx_i,
    output logic             v_o,
    output logic [ACC_W-1:0] sum_o,
    output logic [WIDTH:0]   max_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] smp_o
);
    logic             v_q, v_d;
    logic [WIDTH:0]   err, err_q, err_d, max_q, max_d;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, smp_q, smp_d;

    assign err = exact_i >= approx_i ? exact_i - approx_i : approx_i - exact_i;
    assign sum_ext = {1'b0, sum_q} + {{(ACC_W - WIDTH){1'b0}}, err_q};

    always_comb begin
        v_d   = !clr_i && v_i;
        err_d = v_i ? err : err_q;
        sum_d = clr_i ? '0 : v_q ? (sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0]) : sum_q;
        max_d = clr_i ? '0 : (v_q && err_q > max_q) ? err_q : max_q;
        cnt_d = clr_i ? '0 : (v_q && err_q != '0) ? cnt_q + CNT_W'(1) : cnt_q;
        smp_d = clr_i ? '0 : v_q ? smp_q + CNT_W'(1) : smp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= 1'b0;
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
            smp_q <= '0;
        end else begin
            v_q   <= v_d;
            err_q <= err_d;
            sum_q <= sum_d;
            max_q <= max_d;
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

    assign v_o   = v_q;
    assign sum_o = sum_q;
    assign max_o = max_q;
    assign cnt_o = cnt_q;
    assign smp_o = smp_q;
endmodule

// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor: windowed error metrics for an approximate adder under test
module approx_adder_error_monitor
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_approx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum_abs_err,
    output logic [WIDTH:0]   res_max_err,
    output logic [CNT_W-1:0] res_err_count,
    output logic [CNT_W-1:0] res_samples,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d, acc_q, acc_d;
    logic             s1_v_q, s1_v_d, s2_v;
    logic [WIDTH:0]   exact_q, exact_d, approx_q, approx_d;
    logic             start_ok, accept, last;

    assign start_ok  = start && state_q == IDLE;
    assign in_ready  = state_q == RUN;
    assign res_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign accept    = in_valid && in_ready;
    assign last      = accept && acc_q + CNT_W'(1) == num_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = num_samples == '0 ? DONE : RUN;
            RUN:     if (last) state_d = DRAIN;
            DRAIN:   if (!s1_v_q && !s2_v) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage 1 widens before adding so the carry lands in bit WIDTH
    always_comb begin
        num_d    = start_ok ? num_samples : num_q;
        acc_d    = start_ok ? '0 : accept ? acc_q + CNT_W'(1) : acc_q;
        s1_v_d   = accept;
        exact_d  = accept ? {1'b0, in_a} + {1'b0, in_b} : exact_q;
        approx_d = accept ? in_approx : approx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            num_q    <= '0;
            acc_q    <= '0;
            s1_v_q   <= 1'b0;
            exact_q  <= '0;
            approx_q <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            acc_q    <= acc_d;
            s1_v_q   <= s1_v_d;
            exact_q  <= exact_d;
            approx_q <= approx_d;
        end
    end

    approx_err_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_err (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_ok),
        .v_i      (s1_v_q),
        .exact_i  (exact_q),
        .approx_i (approx_q),
        .v_o      (s2_v),
        .sum_o    (res_sum_abs_err),
        .max_o    (res_max_err),
        .cnt_o    (res_err_count),
        .smp_o    (res_samples)
    );
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb_approx_adder_error_monitor: randomized windows checked against a behavioural error model
module tb_approx_adder_error_monitor;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
    logic [31:0] num_samples = '0;
    logic [15:0] in_a = '0, in_b = '0;
    logic [16:0] in_approx = '0;
    logic        in_ready, res_valid, busy;
    logic [47:0] res_sum_abs_err;
    logic [16:0] res_max_err;
    logic [31:0] res_err_count, res_samples;
    int          ntests = 0, nfail = 0;
    longint      exp_sum = 0, exp_max = 0, exp_cnt = 0, exp_smp = 0;
    logic [15:0] qa[$], qb[$];
    logic [16:0] qp[$];

    always #5 clk = ~clk;

    approx_adder_error_monitor dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum_abs_err(res_sum_abs_err), .res_max_err(res_max_err),
        .res_err_count(res_err_count), .res_samples(res_samples), .busy(busy)
    );

    function automatic void chk(input string nm, input longint act, input longint req);
        ntests++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic void model();
        longint ex, ap, e;
        exp_sum = 0; exp_max = 0; exp_cnt = 0; exp_smp = 0;
        foreach (qa[i]) begin
            ex = longint'(qa[i]) + longint'(qb[i]);
            ap = longint'(qp[i]);
            e  = ex >= ap ? ex - ap : ap - ex;
            exp_sum += e;
            if (e > exp_max) exp_max = e;
            if (e != 0) exp_cnt++;
            exp_smp++;
        end
    endfunction

    // Record fields are meaningful in reset, IDLE and DONE
    always @(negedge clk) begin
        if (rst || res_valid || !busy) begin
            chk("sum_abs_err", longint'(res_sum_abs_err), exp_sum);
            chk("max_err", longint'(res_max_err), exp_max);
            chk("err_count", longint'(res_err_count), exp_cnt);
            chk("samples", longint'(res_samples), exp_smp);
        end
        if (!busy) chk("idle_ready_valid", longint'({in_ready, res_valid}), 0);
        if (res_valid) chk("done_in_ready", longint'(in_ready), 0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic add(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
        qa.push_back(a); qb.push_back(b); qp.push_back(ap);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
        int k = 0;
        in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
        while (!in_ready && k < 20) begin step(); k++; end
        if (!in_ready) chk("accept_timeout", k, 0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic window(input int gap, input int rdy_wait, input bit rdy_pre, input bit poke);
        int lat = 0, idle;
        model();
        res_ready = rdy_pre;
        num_samples = qa.size();
        start = 1'b1;
        step();
        start = 1'b0;
        foreach (qa[i]) begin
            idle = gap >= 0 ? gap : int'($urandom_range(0, -gap));
            in_valid = 1'b0;
            repeat (idle) step();
            send(qa[i], qb[i], qp[i]);
        end
        chk("in_ready_after_window", longint'(in_ready), 0);
        while (!res_valid && lat < 20) begin step(); lat++; end
        chk("done_latency", lat, qa.size() != 0 ? 3 : 0);
        if (rdy_pre) begin
            step();
            chk("pulse_valid", longint'(res_valid), 0);
            chk("pulse_idle", longint'(busy), 0);
        end else begin
            for (int i = 0; i < rdy_wait; i++) begin
                if (poke && i == 2) begin num_samples = 9; start = 1'b1; end
                step();
                start = 1'b0;
                chk("hold_valid", longint'(res_valid), 1);
            end
            res_ready = 1'b1;
            step();
            chk("release_valid", longint'(res_valid), 0);
            chk("release_idle", longint'(busy), 0);
        end
        res_ready = 1'b0;
        qa.delete(); qb.delete(); qp.delete();
    endtask

    initial begin
        int n, ex, mode;
        logic [15:0] a, b;
        logic [16:0] ap;
        step(); step();
        chk("reset_busy", longint'(busy), 0);
        chk("reset_in_ready", longint'(in_ready), 0);
        chk("reset_res_valid", longint'(res_valid), 0);
        rst = 1'b0;
        step();

        add(16'd1, 16'd0, 17'd2); add(16'd3, 16'd3, 17'd4); add(16'd5, 16'd5, 17'd10);
        window(0, 0, 1'b1, 1'b0);
        chk("t1_sum", longint'(res_sum_abs_err), 3);
        chk("t1_max", longint'(res_max_err), 2);
        chk("t1_cnt", longint'(res_err_count), 2);
        chk("t1_smp", longint'(res_samples), 3);

        add(16'hFFFF, 16'hFFFF, 17'h1FFFE);
        window(0, 0, 1'b1, 1'b0);
        chk("carry_sum", longint'(res_sum_abs_err), 0);
        chk("carry_cnt", longint'(res_err_count), 0);
        chk("carry_smp", longint'(res_samples), 1);

        window(0, 0, 1'b0, 1'b0);
        chk("zero_smp", longint'(res_samples), 0);

        add(16'd100, 16'd50, 17'd140); add(16'd7, 16'd8, 17'd20);
        window(0, 5, 1'b0, 1'b1);
        chk("hold_sum", longint'(res_sum_abs_err), 15);
        chk("hold_max", longint'(res_max_err), 10);

        add(16'd1, 16'd1, 17'd2); add(16'd2, 16'd2, 17'd5);
        add(16'd3, 16'd3, 17'd6); add(16'd4, 16'd4, 17'd0);
        window(1, 0, 1'b1, 1'b0);
        chk("toggle_smp", longint'(res_samples), 4);
        chk("toggle_max", longint'(res_max_err), 8);

        num_samples = 4; start = 1'b1;
        step();
        start = 1'b0;
        send(16'd1, 16'd2, 17'd30); send(16'd4, 16'd5, 17'd0);
        exp_sum = 0; exp_max = 0; exp_cnt = 0; exp_smp = 0;
        rst = 1'b1;
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_sum", longint'(res_sum_abs_err), 0);
        chk("rst_smp", longint'(res_samples), 0);
        step();
        rst = 1'b0;
        step();
        add(16'd10, 16'd5, 17'd8);
        window(0, 1, 1'b0, 1'b0);
        chk("post_rst_sum", longint'(res_sum_abs_err), 7);
        chk("post_rst_max", longint'(res_max_err), 7);
        chk("post_rst_cnt", longint'(res_err_count), 1);

        for (int w = 0; w < 15; w++) begin
            n = $urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 12));
            for (int s = 0; s < n; s++) begin
                a = 16'($urandom); b = 16'($urandom);
                ex = int'(a) + int'(b);
                mode = $urandom_range(0, 3);
                ap = mode < 2 ? 17'(ex) : mode == 2 ? 17'(ex + int'($urandom_range(0, 16)) - 8) : 17'($urandom);
                add(a, b, ap);
            end
            window(-2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", nfail);
        $fatal(1);
    end
endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
Sequential error-characterisation block that consumes the output side of the 16-bit approximate ripple-carry adders.
- Accepts a stream of operand pairs together with the approximate sum the adder under test produced for each pair.
- Recomputes the exact sum internally and accumulates error metrics over a programmed sample window: sum of absolute error (for MAE), maximum error, and count of erroneous samples.
- Sits beside the adder in the characterisation harness and returns one result record per window.

Parameters:
WIDTH, 16, operand width; sums are WIDTH+1 bits
CNT_W, 32, width of sample counters
ACC_W, 48, width of absolute-error accumulator

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; opens a window (honoured only in IDLE)
num_samples  input  CNT_W  window length, sampled on the accepted start
in_valid  input  1  sample valid
in_ready  output  1  monitor accepts a sample this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_approx  input  WIDTH+1  approximate sum from the adder under test
res_valid  output  1  result record valid
res_ready  input  1  consumer takes the result
res_sum_abs_err  output  ACC_W  sum of |exact − approx|, saturating
res_max_err  output  WIDTH+1  maximum |exact − approx| in the window
res_err_count  output  CNT_W  samples with approx ≠ exact
res_samples  output  CNT_W  samples actually accumulated
busy  output  1  high in any state except IDLE

Behaviour:
- Reset and clock: one clock domain. Asynchronous active-high reset on rst.
- Reset state: state=IDLE; all result outputs, accumulators and counters = 0; in_ready=0; res_valid=0; busy=0; pipeline valid bits = 0.
- States:
  - IDLE → RUN on start, when num_samples ≠ 0.
  - IDLE → DONE on start, when num_samples = 0; the result record is all zeros.
  - RUN → DRAIN in the cycle the last sample is accepted.
  - DRAIN → DONE when both pipeline valid bits are 0.
  - DONE → IDLE on res_valid & res_ready.
- Start handling: start in any state other than IDLE is ignored. Starting a new window clears all accumulators.
- in_ready = 1 only in RUN. A sample is accepted on in_valid & in_ready. The accepted counter increments on each accept.
- Pipeline, 2 stages:
  - Stage 1 registers exact = in_a + in_b (WIDTH+1 bits, zero-extended) together with in_approx.
  - Stage 2 computes err = |exact − approx| as unsigned WIDTH+1 bits, then updates:
    - sum_abs_err += err, saturating at all-ones;
    - max_err = max(max_err, err);
    - err_count += (err ≠ 0);
    - samples += 1.
  - Latency: a sample accepted at edge t is reflected in the accumulators after edge t+2.
- No input bubbles are required: back-to-back accepts are sustained at 1 sample per cycle.
- Result outputs:
  - Driven from the accumulators and valid only while res_valid=1 (DONE).
  - Held stable while res_valid & !res_ready.
  - Keep their last values in IDLE; cleared at the next start.
- Boundary cases:
  - Overflow of exact sum: carry goes into bit WIDTH, never lost.
  - approx > exact: the absolute value is still taken correctly.
  - res_ready already high on DONE entry: one-cycle res_valid pulse.
  - rst mid-window: immediate return to the reset state; partial results are discarded.

Decomposition:
- Shared package (approx_adder_pkg):
  - state enum {IDLE, RUN, DRAIN, DONE};
  - default WIDTH/CNT_W/ACC_W constants;
  - sum-width constant WIDTH+1;
  - struct for the result record.
- One natural sub-module, approx_err_stage: combinational |exact − approx| plus registered stage 2 accumulation (saturating add, max, count).
- The FSM and handshake stay in the top module.

Test Plan:
- num_samples=3, samples (a,b,approx) = (1,0,2), (3,3,4), (5,5,10), back-to-back, res_ready=1 → res_sum_abs_err=3, res_max_err=2, res_err_count=2, res_samples=3.
- a=0xFFFF, b=0xFFFF, approx=0x1FFFE, num_samples=1 → errors 0, count 0, samples 1 (carry into bit 16 retained).
- start with num_samples=0 → res_valid the next cycle with all-zero record; in_ready never asserts.
- res_ready held 0 for 5 cycles in DONE → res_valid and all result fields stable; second start in that period ignored; IDLE one cycle after res_ready=1.
- in_valid toggled 1/0 during a 4-sample window → exactly 4 accepts; DRAIN lasts until the last sample is accumulated; res_samples=4.
- rst asserted after 2 of 4 accepts → outputs 0 and state IDLE immediately; a new window of 1 sample with error 7 reports sum 7, max 7, count 1.
